// File: rtl/instr_mem_loader.sv
// Assembles UART bytes (LSB first) into instruction words and writes them to consecutive memory addresses until the halt word.
// Optional running XOR checksum of written words enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int                 N_DATA    = 8,
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 7,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en_load_i,
    input  logic [N_DATA-1:0]  rx_data_i,
    input  logic               rx_done_i,
    output logic               wr_en_o,
    output logic [NB_ADDR-1:0] wr_addr_o,
    output logic [NB_DATA-1:0] wr_data_o,
    output logic [NB_ADDR:0]   word_count_o,
    output logic               load_done_o,
    output logic               overflow_o,
    output logic [NB_DATA-1:0] checksum_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [NB_ADDR-1:0] ADDR_MAX  = {NB_ADDR{1'b1}};
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
    localparam logic [NB_ADDR:0]   COUNT_ONE = {{NB_ADDR{1'b0}}, 1'b1};

    state_t              state_r;
    logic [1:0]          byte_cnt_r;
    // Lanes 0..2 only; lane 3 is merged straight into the outgoing word.
    logic [3*N_DATA-1:0] lanes_r;

    assign state_o = state_r;

    // Loader FSM: byte capture, word write strobe and write bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            byte_cnt_r   <= 2'd0;
            lanes_r      <= {(3*N_DATA){1'b0}};
            wr_en_o      <= 1'b0;
            wr_addr_o    <= {NB_ADDR{1'b0}};
            wr_data_o    <= {NB_DATA{1'b0}};
            word_count_o <= {(NB_ADDR+1){1'b0}};
            load_done_o  <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    byte_cnt_r <= 2'd0;
                    if (en_load_i) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (rx_done_i) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0: lanes_r[N_DATA-1:0]          <= rx_data_i;
                            2'd1: lanes_r[2*N_DATA-1:N_DATA]   <= rx_data_i;
                            2'd2: lanes_r[3*N_DATA-1:2*N_DATA] <= rx_data_i;
                            2'd3: begin
                                wr_en_o   <= 1'b1;
                                wr_data_o <= {rx_data_i, lanes_r};
                            end
                            default: lanes_r <= lanes_r;
                        endcase
                    end else begin
                        byte_cnt_r <= byte_cnt_r;
                    end
                    // Disarming drops any partial word; a word completed this cycle is still written.
                    if (!en_load_i) begin
                        state_r    <= ST_IDLE;
                        byte_cnt_r <= 2'd0;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // Write completion overrides the state transition above for terminal conditions.
            if (wr_en_o) begin
                word_count_o <= word_count_o + COUNT_ONE;
                if (wr_addr_o != ADDR_MAX) begin
                    wr_addr_o <= wr_addr_o + ADDR_ONE;
                end else begin
                    wr_addr_o <= wr_addr_o;
                end
                if (wr_data_o == HALT_WORD) begin
                    load_done_o <= 1'b1;
                    state_r     <= ST_DONE;
                end else if (wr_addr_o == ADDR_MAX) begin
                    overflow_o <= 1'b1;
                    state_r    <= ST_ERROR;
                end else begin
                    load_done_o <= load_done_o;
                end
            end else begin
                word_count_o <= word_count_o;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [NB_DATA-1:0] checksum_r;

    // Fold every written word, halt word included, into the running checksum.
    always_ff @(posedge clock) begin
        if (!reset) begin
            checksum_r <= {NB_DATA{1'b0}};
        end else if (wr_en_o) begin
            checksum_r <= checksum_r ^ wr_data_o;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum_o = checksum_r;
`else
    assign checksum_o = {NB_DATA{1'b0}};
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a default instance and a 4-deep (NB_ADDR=2) instance share stimulus.
module tb_instr_mem_loader;

    logic        clock;
    logic        reset;
    logic        en_load;
    logic [7:0]  rx_data;
    logic        rx_done;

    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  word_count;
    logic        load_done;
    logic        overflow;
    logic [31:0] checksum;
    logic [1:0]  state;

    logic        wr_en_s;
    logic [1:0]  wr_addr_s;
    logic [31:0] wr_data_s;
    logic [2:0]  word_count_s;
    logic        load_done_s;
    logic        overflow_s;
    logic [31:0] checksum_s;
    logic [1:0]  state_s;

    typedef struct {
        logic [31:0] data;
        logic [6:0]  addr;
    } exp_t;

    exp_t        q_big[$];
    exp_t        q_small[$];
    logic [6:0]  addr_big;
    logic [1:0]  addr_small;
    logic [31:0] cks_model;
    logic        prev_wr;
    logic        prev_wr_s;
    int          vectors;
    int          miscompares;

    instr_mem_loader dut (
        .clock(clock), .reset(reset), .en_load_i(en_load), .rx_data_i(rx_data), .rx_done_i(rx_done),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .word_count_o(word_count),
        .load_done_o(load_done), .overflow_o(overflow), .checksum_o(checksum), .state_o(state)
    );

    instr_mem_loader #(.NB_ADDR(2)) dut_s (
        .clock(clock), .reset(reset), .en_load_i(en_load), .rx_data_i(rx_data), .rx_done_i(rx_done),
        .wr_en_o(wr_en_s), .wr_addr_o(wr_addr_s), .wr_data_o(wr_data_s), .word_count_o(word_count_s),
        .load_done_o(load_done_s), .overflow_o(overflow_s), .checksum_o(checksum_s), .state_o(state_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: pop the expected write whenever either instance strobes wr_en.
    always @(negedge clock) begin
        exp_t e;
        if (wr_en) begin
            vectors++;
            if (prev_wr) begin
                miscompares++;
                $display("FAIL big_wr_en_consecutive: wr_en high on two cycles in a row");
            end
            vectors++;
            if (q_big.size() == 0) begin
                miscompares++;
                $display("FAIL big_unexpected_write: addr %0h data %0h, no write expected", wr_addr, wr_data);
            end else begin
                e = q_big.pop_front();
                if (wr_data !== e.data || wr_addr !== e.addr) begin
                    miscompares++;
                    $display("FAIL big_write: got addr %0h data %0h, expected addr %0h data %0h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
        if (wr_en_s) begin
            vectors++;
            if (q_small.size() == 0) begin
                miscompares++;
                $display("FAIL small_unexpected_write: addr %0h data %0h, no write expected", wr_addr_s, wr_data_s);
            end else begin
                e = q_small.pop_front();
                if (wr_data_s !== e.data || wr_addr_s !== e.addr[1:0]) begin
                    miscompares++;
                    $display("FAIL small_write: got addr %0h data %0h, expected addr %0h data %0h",
                             wr_addr_s, wr_data_s, e.addr[1:0], e.data);
                end
            end
        end
        prev_wr   = wr_en;
        prev_wr_s = wr_en_s;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        en_load = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        cyc();
        cyc();
        reset      = 1'b1;
        addr_big   = 7'd0;
        addr_small = 2'd0;
        cks_model  = 32'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
    endtask

    // Sends a word LSB first; the expected write is queued as the last byte goes out.
    task automatic send_word(input logic [31:0] w, input logic to_small, input logic drop_last);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                e.data = w;
                e.addr = addr_big;
                q_big.push_back(e);
                addr_big  = addr_big + 7'd1;
                cks_model = cks_model ^ w;
                if (to_small) begin
                    e.addr = {5'd0, addr_small};
                    q_small.push_back(e);
                    addr_small = addr_small + 2'd1;
                end
                if (drop_last) en_load = 1'b0;
            end
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic drain(input string name);
        repeat (6) cyc();
        chk({name, "_big_drain"}, 32'(q_big.size()), 32'd0);
        chk({name, "_small_drain"}, 32'(q_small.size()), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_wr     = 1'b0;
        prev_wr_s   = 1'b0;
        do_reset();

        // Reset state and a single word.
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_done_ovf", 32'({load_done, overflow}), 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        en_load = 1'b1;
        cyc();
        chk("t1_state_load", 32'(state), 32'd1);
        send_word(32'h8023_0000, 1'b1, 1'b0);
        cyc();
        chk("t1_count", 32'(word_count), 32'd1);
        chk("t1_next_addr", 32'(wr_addr), 32'd1);
        drain("t1");

        // Program ending with the halt word.
        do_reset();
        en_load = 1'b1;
        cyc();
        send_word(32'h8023_0000, 1'b1, 1'b0);
        send_word(32'h8024_0000, 1'b1, 1'b0);
        send_word(32'h8025_0000, 1'b1, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("t2_done_not_yet", 32'(load_done), 32'd0);
        cyc();
        chk("t2_load_done", 32'(load_done), 32'd1);
        chk("t2_count", 32'(word_count), 32'd4);
        chk("t2_state", 32'(state), 32'd2);
        chk("t2_overflow", 32'(overflow), 32'd0);
        chk("t2_small_done", 32'(load_done_s), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        chk("t2_checksum", checksum, cks_model);
`else
        chk("t2_checksum_off", checksum, 32'd0);
`endif
        for (int k = 0; k < 4; k++) send_byte(8'hA5);
        chk("t2_count_after_ignored", 32'(word_count), 32'd4);
        drain("t2");

        // Back-to-back ticks across the write cycle.
        do_reset();
        en_load = 1'b1;
        cyc();
        send_word(32'h4433_2211, 1'b1, 1'b0);
        send_word(32'h8877_6655, 1'b1, 1'b0);
        cyc();
        chk("t3_count", 32'(word_count), 32'd2);
        drain("t3");

        // Disarm mid-word discards the partial word.
        do_reset();
        en_load = 1'b1;
        cyc();
        send_byte(8'hAA);
        send_byte(8'hBB);
        en_load = 1'b0;
        cyc();
        chk("t4_state_idle", 32'(state), 32'd0);
        en_load = 1'b1;
        cyc();
        send_word(32'h4433_2211, 1'b1, 1'b0);
        cyc();
        chk("t4_count", 32'(word_count), 32'd1);
        drain("t4");

        // Reset in the middle of a word.
        do_reset();
        en_load = 1'b1;
        cyc();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("t5_state", 32'(state), 32'd0);
        chk("t5_count", 32'(word_count), 32'd0);
        chk("t5_addr", 32'(wr_addr), 32'd0);
        chk("t5_data", wr_data, 32'd0);
        cyc();
        send_word(32'h0706_0504, 1'b1, 1'b0);
        drain("t5");

        // Disarm coincident with the 4th tick still writes the word.
        do_reset();
        en_load = 1'b1;
        cyc();
        send_word(32'hCAFE_F00D, 1'b1, 1'b1);
        chk("t6_state_idle", 32'(state), 32'd0);
        cyc();
        chk("t6_count", 32'(word_count), 32'd1);
        drain("t6");

        // Overflow on the 4-deep instance; the default instance keeps going.
        do_reset();
        en_load = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            send_word(32'h1000_0000 + 32'(i), (i < 4) ? 1'b1 : 1'b0, 1'b0);
            if (i == 3) begin
                chk("t7_small_ovf_not_yet", 32'(overflow_s), 32'd0);
                cyc();
                chk("t7_small_overflow", 32'(overflow_s), 32'd1);
                chk("t7_small_state", 32'(state_s), 32'd3);
                chk("t7_small_done", 32'(load_done_s), 32'd0);
                chk("t7_small_addr_held", 32'(wr_addr_s), 32'd3);
            end
        end
        cyc();
        chk("t7_small_count", 32'(word_count_s), 32'd4);
        chk("t7_big_count", 32'(word_count), 32'd5);
        chk("t7_big_overflow", 32'(overflow), 32'd0);
        drain("t7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
